instr_encoder: RTL and testbench
================================

# instr_encoder

Sequential LEGv8 instruction encoder and instruction-memory loader: the inverse of the CPU's opcode decoder. It accepts symbolic operations (op, registers, immediate) over a valid/ready handshake, range-checks them, and packs them into 32-bit machine words. It writes the words to consecutive word-aligned instruction-memory addresses. It sits between the testbench/boot loader and instruction memory, so that programs are built from the same opcode set the decoder recognises.

## Interface
- `DEPTH`, default 64: instruction-memory capacity in words.
- `ADDR_W`, default 32: byte-address width of `imem_addr`.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  block can accept a request.
- `in_op`  in  4  operation code (`enc_op_t`).
- `in_rd`, `in_rn`, `in_rm`  in  5 each  register fields.
- `in_imm`  in  32  signed immediate; branch offsets are in words.
- `in_last`  in  1  final instruction of the program.
- `start`  in  1  in DONE: clear the address and count, then return to IDLE.
- `imem_we`  out  1  write strobe.
- `imem_addr`  out  ADDR_W  byte address, always a multiple of 4.
- `imem_wdata`  out  32  encoded instruction.
- `imem_ready`  in  1  memory accepts the write this cycle.
- `err`  out  1  one-cycle pulse on a rejected request.
- `done`  out  1  high while in DONE.
- `count`  out  $clog2(DEPTH)+1  number of words written.

## Operation
- **Encodings.** Bits are given high to low.
  - ADDI (0): `1001000100`, imm12, Rn, Rd.
  - ADDS (1): `10101011000`, Rm, shamt=0, Rn, Rd.
  - SUBS (2): `11101011000`, Rm, shamt=0, Rn, Rd.
  - B (3): `000101`, imm26.
  - B.LT (4): `01010100`, imm19, cond=`01011`.
  - BL (5): `100101`, imm26.
  - BR (6): `11010110000`, then zeros in [20:5], then `in_rd` in [4:0].
  - CBZ (7): `10110100`, imm19, Rt=`in_rd`.
  - LDUR (8): `11111000010`, imm9, `00`, Rn, Rt=`in_rd`.
  - STUR (9): `11111000000`, imm9, `00`, Rn, Rt=`in_rd`.
  - Register fields the format does not use are ignored.
- **Legal immediate ranges.**
  - ADDI: 0..4095 (unsigned).
  - LDUR/STUR: -256..255.
  - B.LT/CBZ: -2^18..2^18-1.
  - B/BL: -2^25..2^25-1.
  - Immediates are truncated to field width after the range check passes.
- **Rejection.** An `in_op` value of 10..15, or any out-of-range immediate, is rejected:
  - `err` pulses;
  - nothing is written;
  - the address and `count` are unchanged;
  - `in_last` on a rejected request is ignored.
- **FSM.**
  - IDLE: `in_ready`=1. On an accepted, legal request, register the encoded word and go to WRITE. On an illegal request, pulse `err` and stay in IDLE.
  - WRITE: `imem_we`=1, and `imem_addr`/`imem_wdata` are held stable. When `imem_ready`=1, the write completes: address += 4 and `count`++. Then:
    - go to DONE if the request had `in_last`=1 or `count` reaches DEPTH;
    - otherwise return to IDLE.
  - DONE: `in_ready`=0 and `done`=1. A `start` pulse clears the address and `count` and returns to IDLE. `start` in any other state is ignored.
- **Reset values.** `reset` in any state, including mid-WRITE, returns the block to IDLE with:
  - `imem_we`=0, `imem_addr`=0, `imem_wdata`=0;
  - `err`=0, `done`=0, `count`=0;
  - `in_ready`=1 from the first cycle after reset.

## Timing
- A request is accepted on a cycle where `in_valid` && `in_ready`.
- `imem_we` rises on the next cycle, giving one cycle of latency.
- `err` is asserted on the cycle after a rejected acceptance. `in_ready` stays 1 through that cycle, so back-to-back requests are allowed.
- Throughput is one word per 2 cycles when `imem_ready` is held at 1.
- `in_ready`=0 throughout WRITE and DONE, so no request is ever lost.
- The final address wraps to 0 only via `start` or `reset`; it never wraps silently.

## Structure
- Package `cpu_enc_pkg` holds:
  - `enc_op_t`, the 4-bit enum;
  - the opcode constants;
  - the condition constant LT=`01011`;
  - the immediate bounds.
- Sub-module `instr_field_pack` is purely combinational: op, registers, imm → {word, legal}. The FSM, address counter and word counter live in `instr_encoder`.

## Test plan
- **ADDI.** Request ADDI with rd=1, rn=2, imm=5, then SUBS with rd=3, rn=1, rm=2 → writes `0x91001441` at address 0 and `0xEB020023` at address 4; `count`=2.
- **Branches.** B with imm=-1, then B.LT with imm=2, then CBZ with rd=7, imm=3 → writes `0x17FFFFFF`, `0x5400004B`, `0xB4000067`.
- **Memory ops.** STUR with rd=5, rn=6, imm=-8 → writes `0xF81F80C5`. LDUR with imm=256 → `err` pulses, no write, address stays 4.
- **Backpressure.** Hold `imem_ready`=0 for 3 cycles during WRITE → `imem_we`, `imem_addr` and `imem_wdata` stay stable and `in_ready`=0; exactly one write occurs.
- **Full and restart.** With DEPTH=4, write 4 legal words without `in_last` → `done`=1, `in_ready`=0, `count`=4. `start` → address 0, `count`=0, back in IDLE.
- **Reset and `in_last`.** Assert `reset` mid-WRITE → all outputs take their reset values on the next cycle. A later request with `in_last`=1 → DONE after its single write.

Source files
------------

// File: rtl/cpu_enc_pkg.sv
// Shared LEGv8 encoder definitions: operation codes, opcode fields, branch
// condition and legal immediate bounds.
package cpu_enc_pkg;

  typedef enum logic [3:0] {
    OpAddi = 4'd0,
    OpAdds = 4'd1,
    OpSubs = 4'd2,
    OpB    = 4'd3,
    OpBlt  = 4'd4,
    OpBl   = 4'd5,
    OpBr   = 4'd6,
    OpCbz  = 4'd7,
    OpLdur = 4'd8,
    OpStur = 4'd9
  } enc_op_t;

  localparam logic [9:0]  OpcAddi  = 10'b1001000100;
  localparam logic [10:0] OpcAdds  = 11'b10101011000;
  localparam logic [10:0] OpcSubs  = 11'b11101011000;
  localparam logic [5:0]  OpcB     = 6'b000101;
  localparam logic [7:0]  OpcBcond = 8'b01010100;
  localparam logic [5:0]  OpcBl    = 6'b100101;
  localparam logic [10:0] OpcBr    = 11'b11010110000;
  localparam logic [7:0]  OpcCbz   = 8'b10110100;
  localparam logic [10:0] OpcLdur  = 11'b11111000010;
  localparam logic [10:0] OpcStur  = 11'b11111000000;

  localparam logic [4:0] CondLt = 5'b01011;

  localparam int ImmAddiMin = 0;
  localparam int ImmAddiMax = 4095;
  localparam int ImmMemMin  = -256;
  localparam int ImmMemMax  = 255;
  localparam int ImmCondMin = -(1 << 18);
  localparam int ImmCondMax = (1 << 18) - 1;
  localparam int ImmBrMin   = -(1 << 25);
  localparam int ImmBrMax   = (1 << 25) - 1;

endpackage

// File: rtl/instr_field_pack.sv
// Combinational packer: symbolic operation to 32-bit LEGv8 word plus a legality flag
// covering both the op code and the immediate range.
module instr_field_pack
  import cpu_enc_pkg::*;
(
  input  logic        [3:0]  op,
  input  logic        [4:0]  rd,
  input  logic        [4:0]  rn,
  input  logic        [4:0]  rm,
  input  logic signed [31:0] imm,
  output logic        [31:0] word,
  output logic               legal
);

  always_comb begin
    word  = '0;
    legal = 1'b0;
    case (op)
      OpAddi: begin
        legal = (imm >= ImmAddiMin) && (imm <= ImmAddiMax);
        word  = {OpcAddi, imm[11:0], rn, rd};
      end
      OpAdds: begin
        legal = 1'b1;
        word  = {OpcAdds, rm, 6'd0, rn, rd};
      end
      OpSubs: begin
        legal = 1'b1;
        word  = {OpcSubs, rm, 6'd0, rn, rd};
      end
      OpB: begin
        legal = (imm >= ImmBrMin) && (imm <= ImmBrMax);
        word  = {OpcB, imm[25:0]};
      end
      OpBlt: begin
        legal = (imm >= ImmCondMin) && (imm <= ImmCondMax);
        word  = {OpcBcond, imm[18:0], CondLt};
      end
      OpBl: begin
        legal = (imm >= ImmBrMin) && (imm <= ImmBrMax);
        word  = {OpcBl, imm[25:0]};
      end
      OpBr: begin
        legal = 1'b1;
        word  = {OpcBr, 16'd0, rd};
      end
      OpCbz: begin
        legal = (imm >= ImmCondMin) && (imm <= ImmCondMax);
        word  = {OpcCbz, imm[18:0], rd};
      end
      OpLdur: begin
        legal = (imm >= ImmMemMin) && (imm <= ImmMemMax);
        word  = {OpcLdur, imm[8:0], 2'b00, rn, rd};
      end
      OpStur: begin
        legal = (imm >= ImmMemMin) && (imm <= ImmMemMax);
        word  = {OpcStur, imm[8:0], 2'b00, rn, rd};
      end
      default: begin
        word  = '0;
        legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder and loader: accepts symbolic requests, writes encoded words to
// consecutive word addresses, and stops in DONE on the last instruction or a full memory.
module instr_encoder
  import cpu_enc_pkg::*;
#(
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned ADDR_W = 32,
  localparam int unsigned CountW = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rn,
  input  logic [4:0]        in_rm,
  input  logic [31:0]       in_imm,
  input  logic              in_last,
  input  logic              start,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  input  logic              imem_ready,
  output logic              err,
  output logic              done,
  output logic [CountW-1:0] count
);

  typedef enum logic [1:0] {StIdle, StWrite, StDone} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         wdata_q;
  logic [CountW-1:0]   count_q;
  logic                last_q;
  logic                err_q;
  logic [31:0]         pack_word;
  logic                pack_legal;
  logic                accept;
  logic                write_done;

  instr_field_pack u_pack (
    .op    (in_op),
    .rd    (in_rd),
    .rn    (in_rn),
    .rm    (in_rm),
    .imm   (in_imm),
    .word  (pack_word),
    .legal (pack_legal)
  );

  always_comb begin
    state_d    = state_q;
    in_ready   = (state_q == StIdle);
    accept     = in_valid && in_ready;
    write_done = (state_q == StWrite) && imem_ready;
    unique case (state_q)
      StIdle:  if (accept && pack_legal) state_d = StWrite;
      StWrite: begin
        // count_q still holds the pre-write value here
        if (imem_ready) begin
          state_d = (last_q || (count_q == CountW'(DEPTH - 1))) ? StDone : StIdle;
        end
      end
      StDone:  if (start) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      addr_q  <= '0;
      wdata_q <= '0;
      count_q <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= accept && !pack_legal;
      if (accept && pack_legal) begin
        wdata_q <= pack_word;
        last_q  <= in_last;
      end
      if (write_done) begin
        addr_q  <= addr_q + ADDR_W'(4);
        count_q <= count_q + CountW'(1);
      end
      if ((state_q == StDone) && start) begin
        addr_q  <= '0;
        count_q <= '0;
      end
    end
  end

  assign imem_we    = (state_q == StWrite);
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign err        = err_q;
  assign done       = (state_q == StDone);
  assign count      = count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: directed scenarios from the test plan followed by
// randomized requests checked against an arithmetic reference encoder.
module tb_instr_encoder;
  import cpu_enc_pkg::*;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned ADDR_W = 32;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [3:0]        in_op = '0;
  logic [4:0]        in_rd = '0, in_rn = '0, in_rm = '0;
  logic [31:0]       in_imm = '0;
  logic              in_last = 1'b0;
  logic              start = 1'b0;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              imem_ready = 1'b1;
  logic              err;
  logic              done;
  logic [2:0]        count;

  typedef struct {
    bit          is_err;
    longint      addr;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   m_addr = 0;
  int   m_count = 0;
  bit   m_done = 1'b0;
  bit   rand_ready = 1'b0;
  bit   ready_val = 1'b1;

  instr_encoder #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_rd      (in_rd),
    .in_rn      (in_rn),
    .in_rm      (in_rm),
    .in_imm     (in_imm),
    .in_last    (in_last),
    .start      (start),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .imem_ready (imem_ready),
    .err        (err),
    .done       (done),
    .count      (count)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    #2;
    imem_ready = rand_ready ? ($urandom_range(0, 2) != 0) : ready_val;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  task automatic check_eq(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic longint wrap(input longint v, input longint m);
    return ((v % m) + m) % m;
  endfunction

  function automatic void imm_bounds(input int op, output longint lo, output longint hi);
    case (op)
      0:       begin lo = 0;            hi = 4095;          end
      3, 5:    begin lo = -(64'd1 << 25); hi = (64'd1 << 25) - 1; end
      4, 7:    begin lo = -(64'd1 << 18); hi = (64'd1 << 18) - 1; end
      8, 9:    begin lo = -256;         hi = 255;           end
      default: begin lo = -(64'd1 << 31); hi = (64'd1 << 31) - 1; end
    endcase
  endfunction

  // Reference encoder: fields placed by weighted sums of the opcode prefixes
  function automatic bit ref_encode(input int op, input int rd, input int rn, input int rm,
                                    input int imm, output logic [31:0] w);
    longint lo, hi, v, f;
    bit ok;
    v = longint'(imm);
    imm_bounds(op, lo, hi);
    ok = (op <= 9) && (v >= lo) && (v <= hi);
    case (op)
      0:       f = 64'h9100_0000 + v * 1024 + rn * 32 + rd;
      1:       f = 64'hAB00_0000 + rm * 65536 + rn * 32 + rd;
      2:       f = 64'hEB00_0000 + rm * 65536 + rn * 32 + rd;
      3:       f = 64'h1400_0000 + wrap(v, 64'd1 << 26);
      4:       f = 64'h5400_0000 + wrap(v, 64'd1 << 19) * 32 + 11;
      5:       f = 64'h9400_0000 + wrap(v, 64'd1 << 26);
      6:       f = 64'hD600_0000 + rd;
      7:       f = 64'hB400_0000 + wrap(v, 64'd1 << 19) * 32 + rd;
      8:       f = 64'hF840_0000 + wrap(v, 512) * 4096 + rn * 32 + rd;
      9:       f = 64'hF800_0000 + wrap(v, 512) * 4096 + rn * 32 + rd;
      default: f = 0;
    endcase
    w = f[31:0];
    return ok;
  endfunction

  function automatic int gen_imm(input int op);
    longint lo, hi, v;
    imm_bounds(op, lo, hi);
    case ($urandom_range(0, 5))
      0:       v = longint'($urandom_range(0, 40)) - 20;
      1:       v = lo;
      2:       v = hi;
      3:       v = hi + 1;
      4:       v = lo - 1;
      default: v = longint'(int'($urandom));
    endcase
    return int'(v);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 200) begin
      step();
      n++;
    end
    if (!in_ready) fail("wait_ready_timeout");
  endtask

  task automatic restart();
    int n = 0;
    while (!done && n < 200) begin
      step();
      n++;
    end
    check_eq("done_flag", longint'(done), 1);
    check_eq("done_in_ready", longint'(in_ready), 0);
    check_eq("done_count", longint'(count), m_count);
    start = 1'b1;
    step();
    start = 1'b0;
    check_eq("restart_addr", longint'(imem_addr), 0);
    check_eq("restart_count", longint'(count), 0);
    check_eq("restart_in_ready", longint'(in_ready), 1);
    check_eq("restart_done", longint'(done), 0);
    m_addr  = 0;
    m_count = 0;
    m_done  = 1'b0;
  endtask

  task automatic settle();
    int n = 0;
    while (!(in_ready || done) && n < 200) begin
      step();
      n++;
    end
    if (!(in_ready || done)) fail("settle_timeout");
    check_eq("settle_count", longint'(count), m_count);
    check_eq("settle_done", longint'(done), longint'(m_done));
    check_eq("settle_addr", longint'(imem_addr), m_addr);
  endtask

  task automatic send(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rn,
                      input logic [4:0] rm, input int imm, input bit last,
                      input bit use_lit, input logic [31:0] lit);
    exp_t        e;
    logic [31:0] w;
    bit          legal;
    if (m_done) restart();
    wait_ready();
    legal    = ref_encode(int'(op), int'(rd), int'(rn), int'(rm), imm, w);
    e.is_err = !legal;
    e.addr   = m_addr;
    e.data   = use_lit ? lit : w;
    exp_q.push_back(e);
    if (legal) begin
      m_addr  += 4;
      m_count += 1;
      if (last || m_count == DEPTH) m_done = 1'b1;
    end
    in_op    = op;
    in_rd    = rd;
    in_rn    = rn;
    in_rm    = rm;
    in_imm   = imm;
    in_last  = last;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Monitor: every completed write or err pulse consumes exactly one expectation
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (imem_we && imem_ready) begin
        if (exp_q.size() == 0) begin
          fail("unexpected_write");
        end else begin
          e = exp_q.pop_front();
          check_eq("write_not_err", longint'(e.is_err), 0);
          check_eq("write_addr", longint'(imem_addr), e.addr);
          check_eq("write_data", longint'(imem_wdata), longint'(e.data));
        end
      end
      if (err) begin
        if (exp_q.size() == 0) begin
          fail("unexpected_err");
        end else begin
          e = exp_q.pop_front();
          check_eq("err_expected", longint'(e.is_err), 1);
        end
      end
    end
  end

  initial begin
    logic [ADDR_W-1:0] a0;
    logic [31:0]       w0;
    logic [3:0]        op;

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check_eq("rst_in_ready", longint'(in_ready), 1);
    check_eq("rst_we", longint'(imem_we), 0);
    check_eq("rst_addr", longint'(imem_addr), 0);
    check_eq("rst_wdata", longint'(imem_wdata), 0);
    check_eq("rst_err", longint'(err), 0);
    check_eq("rst_done", longint'(done), 0);
    check_eq("rst_count", longint'(count), 0);

    send(OpAddi, 5'd1, 5'd2, 5'd0, 5, 1'b0, 1'b1, 32'h91001441);
    send(OpSubs, 5'd3, 5'd1, 5'd2, 0, 1'b0, 1'b1, 32'hEB020023);
    settle();
    start = 1'b1;
    step();
    start = 1'b0;
    check_eq("start_ignored_count", longint'(count), 2);
    check_eq("start_ignored_addr", longint'(imem_addr), 8);

    send(OpB,   5'd0, 5'd0, 5'd0, -1, 1'b0, 1'b1, 32'h17FFFFFF);
    send(OpBlt, 5'd0, 5'd0, 5'd0, 2,  1'b0, 1'b1, 32'h5400004B);
    settle();
    check_eq("full_in_ready", longint'(in_ready), 0);
    send(OpCbz, 5'd7, 5'd0, 5'd0, 3, 1'b0, 1'b1, 32'hB4000067);

    send(OpStur, 5'd5, 5'd6, 5'd0, -8,  1'b0, 1'b1, 32'hF81F80C5);
    send(OpLdur, 5'd1, 5'd2, 5'd0, 256, 1'b1, 1'b0, 32'h0);
    settle();

    ready_val = 1'b0;
    step();
    send(OpAddi, 5'd4, 5'd4, 5'd0, 4095, 1'b0, 1'b1, 32'h913FFC84);
    a0 = imem_addr;
    w0 = imem_wdata;
    check_eq("stall_first_data", longint'(w0), longint'(32'h913FFC84));
    for (int i = 0; i < 3; i++) begin
      check_eq("stall_we", longint'(imem_we), 1);
      check_eq("stall_in_ready", longint'(in_ready), 0);
      check_eq("stall_addr", longint'(imem_addr), longint'(a0));
      check_eq("stall_data", longint'(imem_wdata), longint'(w0));
      step();
    end
    ready_val = 1'b1;
    settle();

    // Reset mid-WRITE: this request is abandoned, so it carries no expectation
    ready_val = 1'b0;
    step();
    wait_ready();
    in_op    = OpAdds;
    in_rd    = 5'd9;
    in_rn    = 5'd8;
    in_rm    = 5'd7;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check_eq("pre_reset_we", longint'(imem_we), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_eq("midrst_we", longint'(imem_we), 0);
    check_eq("midrst_addr", longint'(imem_addr), 0);
    check_eq("midrst_wdata", longint'(imem_wdata), 0);
    check_eq("midrst_err", longint'(err), 0);
    check_eq("midrst_done", longint'(done), 0);
    check_eq("midrst_count", longint'(count), 0);
    check_eq("midrst_in_ready", longint'(in_ready), 1);
    m_addr    = 0;
    m_count   = 0;
    m_done    = 1'b0;
    ready_val = 1'b1;

    send(OpBr, 5'd3, 5'd0, 5'd0, 0, 1'b1, 1'b1, 32'hD6000003);
    settle();

    rand_ready = 1'b1;
    for (int i = 0; i < 80; i++) begin
      op = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      send(op, 5'($urandom), 5'($urandom), 5'($urandom), gen_imm(int'(op)),
           ($urandom_range(0, 5) == 0), 1'b0, 32'h0);
      if (i % 4 == 0) settle();
    end
    settle();
    rand_ready = 1'b0;
    repeat (3) step();
    check_eq("queue_drained", longint'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
